scrambler_descrambler_loopback_p: RTL and testbench
===================================================

Name: scrambler_descrambler_loopback_p

Overview:
- Parametrised successor to the 1-bit integrated scrambler/descrambler pair.
- Processes DATA_W bits per clock with a configurable LFSR polynomial, seed and mode: additive (frame-synchronous) or multiplicative (self-synchronising).
- Scrambler feeds an internal descrambler through an optional error-injection point.
- A built-in checker compares descrambled data against delayed input, and reports lock plus a saturating bit-error count.
- Used as a link BIST/loopback block and as the golden model for the serial link path.

Parameters:
- DATA_W, 8, bits processed per beat (1..32).
- LFSR_W, 7, LFSR length (2..31).
- POLY, 7'h60, tap mask; bit i set means state[i] contributes to feedback.
- SEED, 7'h7F, reset/reseed value of both LFSRs (must be nonzero in additive mode).
- MODE, 0, 0 = additive, 1 = multiplicative.
- CNT_W, 16, error-counter width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- enable  input  1  global advance; low = every register holds
- reseed  input  1  sync pulse: reload both LFSRs with SEED, clear lock, count and pipeline valids
- in_valid  input  1  in_data carries a beat
- in_data  input  DATA_W  plaintext, LSB transmitted first
- err_inject  input  1  flip bit 0 of the scrambled word on the descrambler path only
- scrambled_out  output  DATA_W  registered scrambler output
- scr_valid  output  1  scrambled_out valid
- descrambled_out  output  DATA_W  registered descrambler output
- dsc_valid  output  1  descrambled_out valid
- lock  output  1  descrambler synchronised
- err_cnt  output  CNT_W  saturating mismatched-bit count
- err_flag  output  1  registered; high for the one beat in which any mismatch is counted

Behaviour:
- Reset (rst=0, async): LFSRs = SEED; scrambled_out, descrambled_out, scr_valid, dsc_valid, lock, err_cnt and err_flag = 0; reference delay line cleared.
- Advance rule: state changes only when enable=1. A beat is consumed when enable & in_valid.
- Per-bit step, for bits j = 0..DATA_W-1 in order within one cycle. Let p = parity(state & POLY) and shift = {state[LFSR_W-2:0], x}.
  - Additive: out_j = d_j ^ p, x = p. The descrambler is identical with its own LFSR.
  - Multiplicative scrambler: s_j = d_j ^ p, x = s_j.
  - Multiplicative descrambler: d_j = s_j ^ p, x = s_j, using the received bit after injection.
- Latency: scrambled_out 1 cycle after the accepted beat; descrambled_out 2 cycles after it. Valids track beats in the same pipeline.
- LFSRs advance only on valid beats. Idle cycles (in_valid=0, enable=1) clear the valid flags and hold LFSR state.
- err_inject is sampled with the scrambler output: the descrambler sees scrambled_out ^ 1. scrambled_out itself is unaffected.
- Lock:
  - Additive: lock rises with the first dsc_valid beat.
  - Multiplicative: lock rises once at least LFSR_W bits have entered the descrambler since reset/reseed. The internal bit counter saturates.
- Checker: in_data is delayed 2 beats. On each dsc_valid & lock beat, err_cnt += popcount(descrambled_out ^ delayed), saturating at all-ones; err_flag = (popcount != 0). Beats before lock are not counted.
- reseed with in_valid in the same cycle: reseed wins and the beat is dropped. Pipeline valids clear next cycle.
- Reset mid-stream: everything returns immediately to reset values.
- With enable=0: err_inject, reseed and in_valid are ignored.

Test Plan:
- Additive, defaults, reset release, one beat in_data=0x00 -> scrambled_out=0x40 one cycle later; descrambled_out=0x00 one cycle after that; lock=1; err_cnt=0.
- Multiplicative, defaults, in_data=0x00 -> scrambled_out=0x40.
- Multiplicative: 64 random beats with no errors -> descrambled_out equals input delayed 2 beats, err_cnt=0.
- Additive, steady stream, err_inject=1 for one beat -> err_cnt=1 and err_flag pulses once.
- Multiplicative, same stimulus -> err_cnt=3 (1 + two taps, error multiplication), spread over at most 2 beats.
- Invalid reseed and saturation:
  - in_valid gaps every other cycle -> outputs identical to the gapless sequence.
  - reseed mid-stream -> lock drops; the next beat 0x00 scrambles to 0x40 again.
  - CNT_W=4 with continuous injection -> err_cnt holds at 0xF.
  - rst asserted mid-stream clears all outputs within the same cycle.

Source files
------------

// File: rtl/scrambler_descrambler_loopback_p.sv
// Parametrised scrambler -> error-injection point -> descrambler loopback with a
// built-in checker that reports lock and a saturating mismatched-bit count.
module scrambler_descrambler_loopback_p #(
    parameter int                DATA_W = 8,
    parameter int                LFSR_W = 7,
    parameter logic [LFSR_W-1:0] POLY   = 7'h60,
    parameter logic [LFSR_W-1:0] SEED   = 7'h7F,
    parameter int                MODE   = 0,
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              reseed,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              err_inject,
    output logic [DATA_W-1:0] scrambled_out,
    output logic              scr_valid,
    output logic [DATA_W-1:0] descrambled_out,
    output logic              dsc_valid,
    output logic              lock,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_flag
);

    localparam int PC_W  = $clog2(DATA_W + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [LFSR_W-1:0] scr_lfsr, dsc_lfsr;
    logic [LFSR_W-1:0] scr_state, dsc_state;
    logic [DATA_W-1:0] scr_word, dsc_word, rx_word, mis_word, ref_data;
    logic              inj_r;
    logic              scr_p, dsc_p;
    logic [SUM_W-1:0]  pop, cnt_sum;
    logic [CNT_W-1:0]  cnt_next;
    logic [5:0]        bits_seen, bits_next;
    logic [6:0]        bits_sum;
    logic              lock_next;

    // NOTE: blocking assignments chain DATA_W LFSR steps inside a single cycle.
    always_comb begin
        scr_state = scr_lfsr;
        scr_word  = '0;
        scr_p     = 1'b0;
        for (int j = 0; j < DATA_W; j++) begin
            scr_p       = ^(scr_state & POLY);
            scr_word[j] = in_data[j] ^ scr_p;
            scr_state   = {scr_state[LFSR_W-2:0], (MODE != 0) ? scr_word[j] : scr_p};
        end
    end

    // The descrambler always works on the received word, i.e. after injection.
    always_comb begin
        rx_word    = scrambled_out;
        rx_word[0] = scrambled_out[0] ^ inj_r;
        dsc_state  = dsc_lfsr;
        dsc_word   = '0;
        dsc_p      = 1'b0;
        for (int j = 0; j < DATA_W; j++) begin
            dsc_p       = ^(dsc_state & POLY);
            dsc_word[j] = rx_word[j] ^ dsc_p;
            dsc_state   = {dsc_state[LFSR_W-2:0], (MODE != 0) ? rx_word[j] : dsc_p};
        end
    end

    always_comb begin
        mis_word = dsc_word ^ ref_data;
        pop      = '0;
        for (int j = 0; j < DATA_W; j++) begin
            pop = pop + SUM_W'(mis_word[j]);
        end
        cnt_sum  = SUM_W'(err_cnt) + pop;
        cnt_next = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end

    // Multiplicative lock needs LFSR_W received bits; the counter saturates there.
    always_comb begin
        bits_sum  = {1'b0, bits_seen} + 7'(DATA_W);
        bits_next = (bits_sum >= 7'(LFSR_W)) ? 6'(LFSR_W) : bits_sum[5:0];
        lock_next = (MODE == 0) || (bits_sum >= 7'(LFSR_W));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scr_lfsr        <= SEED;
            dsc_lfsr        <= SEED;
            scrambled_out   <= '0;
            scr_valid       <= 1'b0;
            descrambled_out <= '0;
            dsc_valid       <= 1'b0;
            lock            <= 1'b0;
            err_cnt         <= '0;
            err_flag        <= 1'b0;
            inj_r           <= 1'b0;
            ref_data        <= '0;
            bits_seen       <= '0;
        end else if (enable) begin
            if (reseed) begin
                scr_lfsr  <= SEED;
                dsc_lfsr  <= SEED;
                scr_valid <= 1'b0;
                dsc_valid <= 1'b0;
                lock      <= 1'b0;
                err_cnt   <= '0;
                err_flag  <= 1'b0;
                bits_seen <= '0;
            end else begin
                if (in_valid) begin
                    scr_lfsr      <= scr_state;
                    scrambled_out <= scr_word;
                    inj_r         <= err_inject;
                    ref_data      <= in_data;
                end
                scr_valid <= in_valid;

                if (scr_valid) begin
                    dsc_lfsr        <= dsc_state;
                    descrambled_out <= dsc_word;
                    bits_seen       <= bits_next;
                    lock            <= lock_next;
                    if (lock_next) begin
                        err_cnt <= cnt_next;
                    end
                end
                dsc_valid <= scr_valid;
                err_flag  <= scr_valid && lock_next && (pop != '0);
            end
        end
    end

endmodule

// File: tb/tb_scrambler_descrambler_loopback_p.sv
// Bench for the scrambler/descrambler loopback: three instances (additive,
// multiplicative, additive with a 4-bit counter) share one stimulus stream.
module tb_scrambler_descrambler_loopback_p;

    localparam int         DW   = 8;
    localparam int         LW   = 7;
    localparam logic [6:0] POLY = 7'h60;
    localparam logic [6:0] SEED = 7'h7F;
    localparam int         HIST = 8192;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       reseed = 1'b0;
    logic       in_valid = 1'b0;
    logic       err_inject = 1'b0;
    logic [7:0] in_data = '0;

    logic [7:0]  scr_o [3];
    logic [7:0]  dsc_o [3];
    logic        sv_o [3];
    logic        dv_o [3];
    logic        lock_o [3];
    logic        flag_o [3];
    logic [15:0] cnt_a, cnt_m;
    logic [3:0]  cnt_s;

    int checks = 0;
    int errors = 0;

    // Reference model: bit streams defined by the recurrence "new bit from taps
    // over earlier stream bits", with negative indices supplied by the seed.
    logic tx_s [3][HIST];
    logic rx_s [3][HIST];
    int   tx_n [3];
    int   rx_n [3];
    logic [7:0] e_scr [3], e_dsc [3], e_ref [3];
    logic       e_sv [3], e_dv [3], e_lock [3], e_flag [3], e_inj [3];
    int         e_cnt [3], rx_bits [3];
    int         pulses [3];

    logic [7:0] sent_q [$];
    logic [7:0] rec_scr [2][16];
    logic [7:0] rec_dsc [2][16];
    int         ks, kd;

    always #5 clk = ~clk;

    scrambler_descrambler_loopback_p #(.MODE(0)) u_add (
        .clk(clk), .rst(rst), .enable(enable), .reseed(reseed), .in_valid(in_valid),
        .in_data(in_data), .err_inject(err_inject), .scrambled_out(scr_o[0]),
        .scr_valid(sv_o[0]), .descrambled_out(dsc_o[0]), .dsc_valid(dv_o[0]),
        .lock(lock_o[0]), .err_cnt(cnt_a), .err_flag(flag_o[0])
    );

    scrambler_descrambler_loopback_p #(.MODE(1)) u_mul (
        .clk(clk), .rst(rst), .enable(enable), .reseed(reseed), .in_valid(in_valid),
        .in_data(in_data), .err_inject(err_inject), .scrambled_out(scr_o[1]),
        .scr_valid(sv_o[1]), .descrambled_out(dsc_o[1]), .dsc_valid(dv_o[1]),
        .lock(lock_o[1]), .err_cnt(cnt_m), .err_flag(flag_o[1])
    );

    scrambler_descrambler_loopback_p #(.MODE(0), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .enable(enable), .reseed(reseed), .in_valid(in_valid),
        .in_data(in_data), .err_inject(err_inject), .scrambled_out(scr_o[2]),
        .scr_valid(sv_o[2]), .descrambled_out(dsc_o[2]), .dsc_valid(dv_o[2]),
        .lock(lock_o[2]), .err_cnt(cnt_s), .err_flag(flag_o[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int m);
        case (m)
            0:       return 32'(cnt_a);
            1:       return 32'(cnt_m);
            default: return 32'(cnt_s);
        endcase
    endfunction

    function automatic logic hist_bit(input int m, input int k, input bit rx);
        logic [6:0] sd = SEED;
        if (k < 0) return sd[-k-1];
        return rx ? rx_s[m][k] : tx_s[m][k];
    endfunction

    function automatic logic taps(input int m, input int n, input bit rx);
        logic [6:0] pl = POLY;
        logic       p  = 1'b0;
        for (int i = 0; i < LW; i++) begin
            if (pl[i]) p ^= hist_bit(m, n - 1 - i, rx);
        end
        return p;
    endfunction

    task automatic model_scramble(input int m, input logic [7:0] d, output logic [7:0] w);
        logic p;
        w = '0;
        for (int j = 0; j < DW; j++) begin
            p = taps(m, tx_n[m], 1'b0);
            w[j] = d[j] ^ p;
            tx_s[m][tx_n[m]] = (m == 1) ? w[j] : p;
            tx_n[m]++;
        end
    endtask

    task automatic model_descramble(input int m, input logic [7:0] r, output logic [7:0] w);
        logic p;
        w = '0;
        for (int j = 0; j < DW; j++) begin
            p = taps(m, rx_n[m], 1'b1);
            w[j] = r[j] ^ p;
            rx_s[m][rx_n[m]] = (m == 1) ? r[j] : p;
            rx_n[m]++;
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            tx_n[m] = 0; rx_n[m] = 0; rx_bits[m] = 0;
            e_scr[m] = '0; e_dsc[m] = '0; e_ref[m] = '0; e_inj[m] = 1'b0;
            e_sv[m] = 1'b0; e_dv[m] = 1'b0; e_lock[m] = 1'b0; e_flag[m] = 1'b0;
            e_cnt[m] = 0;
        end
    endtask

    task automatic model_clock(input logic v, input logic [7:0] d, input logic inj,
                               input logic rs, input logic en);
        logic [7:0] w, r;
        int         e, cmax;
        logic       lk;
        for (int m = 0; m < 3; m++) begin
            cmax = (m == 2) ? 15 : 65535;
            if (!en) continue;
            if (rs) begin
                tx_n[m] = 0; rx_n[m] = 0; rx_bits[m] = 0;
                e_sv[m] = 1'b0; e_dv[m] = 1'b0; e_lock[m] = 1'b0;
                e_cnt[m] = 0; e_flag[m] = 1'b0;
                continue;
            end
            if (e_sv[m]) begin
                r = e_scr[m];
                r[0] = r[0] ^ e_inj[m];
                model_descramble(m, r, w);
                e_dsc[m] = w;
                e_dv[m] = 1'b1;
                rx_bits[m] += DW;
                lk = (m != 1) || (rx_bits[m] >= LW);
                e_lock[m] = lk;
                if (lk) begin
                    e = $countones(w ^ e_ref[m]);
                    e_cnt[m] = (e_cnt[m] + e > cmax) ? cmax : e_cnt[m] + e;
                    e_flag[m] = (e != 0);
                end else begin
                    e_flag[m] = 1'b0;
                end
            end else begin
                e_dv[m] = 1'b0;
                e_flag[m] = 1'b0;
            end
            if (v) begin
                model_scramble(m, d, w);
                e_scr[m] = w; e_inj[m] = inj; e_ref[m] = d; e_sv[m] = 1'b1;
            end else begin
                e_sv[m] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("scr%0d", m),  32'(scr_o[m]),  32'(e_scr[m]));
            chk($sformatf("sv%0d", m),   32'(sv_o[m]),   32'(e_sv[m]));
            chk($sformatf("dsc%0d", m),  32'(dsc_o[m]),  32'(e_dsc[m]));
            chk($sformatf("dv%0d", m),   32'(dv_o[m]),   32'(e_dv[m]));
            chk($sformatf("lock%0d", m), 32'(lock_o[m]), 32'(e_lock[m]));
            chk($sformatf("cnt%0d", m),  cnt_of(m),      32'(e_cnt[m]));
            chk($sformatf("flag%0d", m), 32'(flag_o[m]), 32'(e_flag[m]));
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic inj,
                        input logic rs, input logic en);
        in_valid = v; in_data = d; err_inject = inj; reseed = rs; enable = en;
        @(posedge clk);
        model_clock(v, d, inj, rs, en);
        @(negedge clk);
        check_all();
        for (int m = 0; m < 3; m++) begin
            if (flag_o[m] === 1'b1) pulses[m]++;
        end
    endtask

    task automatic track_loop();
        logic [7:0] exp;
        if (e_dv[1] && sent_q.size() > 0) begin
            exp = sent_q.pop_front();
            chk("loop_mul", 32'(dsc_o[1]), 32'(exp));
            chk("loop_add", 32'(dsc_o[0]), 32'(exp));
        end
    endtask

    task automatic gap_obs(input bit record);
        for (int m = 0; m < 2; m++) begin
            if (e_sv[m]) begin
                if (record) rec_scr[m][ks] = e_scr[m];
                else chk($sformatf("gap_scr%0d", m), 32'(scr_o[m]), 32'(rec_scr[m][ks]));
            end
            if (e_dv[m]) begin
                if (record) rec_dsc[m][kd] = e_dsc[m];
                else chk($sformatf("gap_dsc%0d", m), 32'(dsc_o[m]), 32'(rec_dsc[m][kd]));
            end
        end
        if (e_sv[0]) ks++;
        if (e_dv[0]) kd++;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] gd [12];

        model_reset();
        for (int m = 0; m < 3; m++) pulses[m] = 0;
        enable = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b1;

        // First beat of zeros after reset release.
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("first_scr_add", 32'(scr_o[0]), 32'h40);
        chk("first_scr_mul", 32'(scr_o[1]), 32'h40);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("first_dsc_add", 32'(dsc_o[0]), 32'h00);
        chk("first_lock_add", 32'(lock_o[0]), 32'h1);
        chk("first_cnt_add", 32'(cnt_a), 32'h0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Random error-free stream.
        for (int i = 0; i < 64; i++) begin
            d = 8'($urandom);
            sent_q.push_back(d);
            step(1'b1, d, 1'b0, 1'b0, 1'b1);
            track_loop();
        end
        repeat (2) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            track_loop();
        end
        chk("rand_cnt_mul", 32'(cnt_m), 32'h0);
        chk("rand_cnt_add", 32'(cnt_a), 32'h0);

        // Single injected error; the beat offered with reseed is dropped.
        step(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b1);
        chk("reseed_lock_add", 32'(lock_o[0]), 32'h0);
        chk("reseed_lock_mul", 32'(lock_o[1]), 32'h0);
        for (int m = 0; m < 3; m++) pulses[m] = 0;
        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), (i == 3), 1'b0, 1'b1);
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("inj_cnt_add", 32'(cnt_a), 32'd1);
        chk("inj_flag_pulses_add", 32'(pulses[0]), 32'd1);
        chk("inj_cnt_mul", 32'(cnt_m), 32'd3);
        chk("inj_flag_span_mul", 32'(pulses[1] >= 1 && pulses[1] <= 2), 32'd1);

        // Gapless reference run, then the same data with idle cycles between beats.
        for (int i = 0; i < 12; i++) gd[i] = 8'($urandom);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        ks = 0; kd = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, gd[i], 1'b0, 1'b0, 1'b1);
            gap_obs(1'b1);
        end
        repeat (2) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            gap_obs(1'b1);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        ks = 0; kd = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, gd[i], 1'b0, 1'b0, 1'b1);
            gap_obs(1'b0);
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            gap_obs(1'b0);
        end
        chk("gap_beats", 32'(kd), 32'd12);

        // Reseed mid-stream.
        repeat (3) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
        chk("mid_reseed_lock_mul", 32'(lock_o[1]), 32'h0);
        chk("mid_reseed_sv", 32'(sv_o[0]), 32'h0);
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("mid_reseed_scr_add", 32'(scr_o[0]), 32'h40);
        chk("mid_reseed_scr_mul", 32'(scr_o[1]), 32'h40);
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // enable low: reseed, in_valid and err_inject are all ignored.
        repeat (2) step(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
        chk("hold_lock", 32'(lock_o[0]), 32'h1);

        // Continuous injection drives the 4-bit counter into saturation.
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1);
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("sat_cnt_small", 32'(cnt_s), 32'hF);
        chk("sat_cnt_add", 32'(cnt_a), 32'd20);
        chk("sat_cnt_mul", 32'(cnt_m), 32'd60);

        // Asynchronous reset mid-stream, checked before any clock edge.
        repeat (3) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("arst_scr%0d", m),  32'(scr_o[m]),  32'h0);
            chk($sformatf("arst_sv%0d", m),   32'(sv_o[m]),   32'h0);
            chk($sformatf("arst_dsc%0d", m),  32'(dsc_o[m]),  32'h0);
            chk($sformatf("arst_dv%0d", m),   32'(dv_o[m]),   32'h0);
            chk($sformatf("arst_lock%0d", m), 32'(lock_o[m]), 32'h0);
            chk($sformatf("arst_cnt%0d", m),  cnt_of(m),      32'h0);
            chk($sformatf("arst_flag%0d", m), 32'(flag_o[m]), 32'h0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("post_rst_scr_add", 32'(scr_o[0]), 32'h40);
        chk("post_rst_scr_mul", 32'(scr_o[1]), 32'h40);
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
